// File: rtl/pc_update_unit.sv
// ============================================================================
// Module   : pc_update_unit
// Purpose  : Commits the next program counter (seq/branch/jump/JAL/JR/halt)
//            on the rising edge of the PCWriteCond strobe.
// Options  : PC_PERF_CNT_EN adds saturating commit/taken counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_update_unit #(
    parameter int              PC_W     = 32,
    parameter int              JT_W     = 26,
    parameter int              IMM_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Op,
    input  logic             zeroFlag,
    input  logic             PCWriteCond,
    input  logic [IMM_W-1:0] imm,
    input  logic [JT_W-1:0]  jump_target,
    input  logic [PC_W-1:0]  reg_target,
    output logic [PC_W-1:0]  pc_out,
    output logic [PC_W-1:0]  ret_addr,
    output logic             ret_valid,
    output logic             branch_taken,
    output logic             halted
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]      commit_count,
    output logic [31:0]      taken_count
`endif
);

    localparam logic [4:0] c_OP_JR   = 5'b00110;
    localparam logic [4:0] c_OP_BEQ  = 5'b01011;
    localparam logic [4:0] c_OP_J    = 5'b01100;
    localparam logic [4:0] c_OP_JAL  = 5'b01101;
    localparam logic [4:0] c_OP_HALT = 5'b11111;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic            r_pcWriteCondQ;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_retAddr;
    logic            r_retValid;
    logic            r_branchTaken;

    logic            w_commit;
    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_immExt;
    logic [PC_W-1:0] w_jumpAddr;
    logic [PC_W-1:0] w_pcNext;
    logic [PC_W-1:0] w_retAddrNext;
    logic            w_retValidNext;
    logic            w_takenNext;

    // Rising edge of the strobe only, so a held strobe commits once; ignored when halted.
    assign w_commit   = PCWriteCond & ~r_pcWriteCondQ & (r_state == ST_RUN);
    assign w_seq      = r_pc + PC_W'(1);
    assign w_immExt   = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign w_jumpAddr = {r_pc[PC_W-1:JT_W], jump_target};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_pcWriteCondQ <= 1'b0;
            r_pc           <= RESET_PC;
            r_retAddr      <= '0;
            r_retValid     <= 1'b0;
            r_branchTaken  <= 1'b0;
        end else begin
            r_state        <= w_stateNext;
            r_pcWriteCondQ <= PCWriteCond;
            r_pc           <= w_pcNext;
            r_retAddr      <= w_retAddrNext;
            r_retValid     <= w_retValidNext;
            r_branchTaken  <= w_takenNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_retAddrNext  = r_retAddr;
        w_retValidNext = 1'b0;
        w_takenNext    = 1'b0;
        if (w_commit) begin
            case (Op)
                c_OP_BEQ: begin
                    if (zeroFlag) begin
                        w_pcNext    = w_seq + w_immExt;
                        w_takenNext = 1'b1;
                    end else begin
                        w_pcNext    = w_seq;
                    end
                end
                c_OP_J: w_pcNext = w_jumpAddr;
                c_OP_JAL: begin
                    w_pcNext       = w_jumpAddr;
                    w_retAddrNext  = w_seq;
                    w_retValidNext = 1'b1;
                end
                c_OP_JR:   w_pcNext    = reg_target;
                c_OP_HALT: w_stateNext = ST_HALTED;
                default:   w_pcNext    = w_seq;
            endcase
        end
    end

    assign pc_out       = r_pc;
    assign ret_addr     = r_retAddr;
    assign ret_valid    = r_retValid;
    assign branch_taken = r_branchTaken;
    assign halted       = (r_state == ST_HALTED);

`ifdef PC_PERF_CNT_EN
    logic [31:0] r_commitCount;
    logic [31:0] r_takenCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commitCount <= '0;
            r_takenCount  <= '0;
        end else begin
            if (w_commit && (r_commitCount != '1))
                r_commitCount <= r_commitCount + 32'd1;
            if (w_takenNext && (r_takenCount != '1))
                r_takenCount <= r_takenCount + 32'd1;
        end
    end

    assign commit_count = r_commitCount;
    assign taken_count  = r_takenCount;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
// ============================================================================
// Module   : tb_pc_update_unit
// Purpose  : Directed self-checking bench for pc_update_unit (RESET_PC=0x10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_update_unit;

    localparam logic [31:0] c_RESET_PC = 32'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Op;
    logic        zeroFlag;
    logic        PCWriteCond;
    logic [15:0] imm;
    logic [25:0] jump_target;
    logic [31:0] reg_target;
    logic [31:0] pc_out;
    logic [31:0] ret_addr;
    logic        ret_valid;
    logic        branch_taken;
    logic        halted;
`ifdef PC_PERF_CNT_EN
    logic [31:0] commit_count;
    logic [31:0] taken_count;
`endif

    int checks   = 0;
    int failures = 0;

    pc_update_unit #(
        .PC_W     (32),
        .JT_W     (26),
        .IMM_W    (16),
        .RESET_PC (c_RESET_PC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Op           (Op),
        .zeroFlag     (zeroFlag),
        .PCWriteCond  (PCWriteCond),
        .imm          (imm),
        .jump_target  (jump_target),
        .reg_target   (reg_target),
        .pc_out       (pc_out),
        .ret_addr     (ret_addr),
        .ret_valid    (ret_valid),
        .branch_taken (branch_taken),
        .halted       (halted)
`ifdef PC_PERF_CNT_EN
        ,
        .commit_count (commit_count),
        .taken_count  (taken_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns at the next falling edge, when pulses are visible.
    task automatic strobe(input logic [4:0] op, input logic zf);
        @(negedge clk);
        Op          = op;
        zeroFlag    = zf;
        PCWriteCond = 1'b1;
        @(negedge clk);
        PCWriteCond = 1'b0;
    endtask

    task automatic setPc(input logic [31:0] value);
        reg_target = value;
        strobe(5'b00110, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; Op = '0; zeroFlag = 1'b0; PCWriteCond = 1'b0;
        imm = '0; jump_target = '0; reg_target = '0;
        repeat (2) @(negedge clk);
        check("rst_pc",        pc_out,              c_RESET_PC);
        check("rst_ret_addr",  ret_addr,            32'h0);
        check("rst_ret_valid", {31'b0, ret_valid},   32'h0);
        check("rst_taken",     {31'b0, branch_taken}, 32'h0);
        check("rst_halted",    {31'b0, halted},      32'h0);
        rst_n = 1'b1;

        // Sequential NOPs
        strobe(5'b00000, 1'b0); check("seq1", pc_out, 32'h11);
        check("seq1_taken", {31'b0, branch_taken}, 32'h0);
        strobe(5'b00000, 1'b0); check("seq2", pc_out, 32'h12);
        check("seq2_retv", {31'b0, ret_valid}, 32'h0);
        strobe(5'b00000, 1'b0); check("seq3", pc_out, 32'h13);

        // BEQ taken / not taken
        setPc(32'h20); check("jr_20", pc_out, 32'h20);
        imm = 16'hFFFD;
        strobe(5'b01011, 1'b1);
        check("beq_taken_pc",  pc_out, 32'h1E);
        check("beq_taken_pls", {31'b0, branch_taken}, 32'h1);
        @(negedge clk);
        check("beq_taken_end", {31'b0, branch_taken}, 32'h0);
        setPc(32'h20);
        strobe(5'b01011, 1'b0);
        check("beq_nt_pc",  pc_out, 32'h21);
        check("beq_nt_pls", {31'b0, branch_taken}, 32'h0);

        // JAL then JR back to the return address
        setPc(32'hF000_0005);
        jump_target = 26'h0000123;
        strobe(5'b01101, 1'b0);
        check("jal_pc",   pc_out,   32'hF000_0123);
        check("jal_ret",  ret_addr, 32'hF000_0006);
        check("jal_retv", {31'b0, ret_valid}, 32'h1);
        @(negedge clk);
        check("jal_retv_end", {31'b0, ret_valid}, 32'h0);
        setPc(32'hF000_0006);
        check("jr_ret_pc", pc_out, 32'hF000_0006);

        // J keeps upper PC bits
        strobe(5'b01100, 1'b0);
        check("j_pc", pc_out, 32'hF000_0123);

        // Wrap and held strobe
        setPc(32'hFFFF_FFFF);
        strobe(5'b01111, 1'b0);
        check("wrap_pc", pc_out, 32'h0);
        @(negedge clk);
        Op = 5'b01111; PCWriteCond = 1'b1;
        repeat (3) @(negedge clk);
        PCWriteCond = 1'b0;
        @(negedge clk);
        check("held_pc", pc_out, 32'h1);

        // HALT freezes everything until reset
        strobe(5'b11111, 1'b0);
        check("halt_flag", {31'b0, halted}, 32'h1);
        check("halt_pc",   pc_out, 32'h1);
        strobe(5'b00000, 1'b0);
        reg_target = 32'h55;
        strobe(5'b00110, 1'b0);
        strobe(5'b01011, 1'b1);
        check("halt_frozen_pc",  pc_out, 32'h1);
        check("halt_no_taken",   {31'b0, branch_taken}, 32'h0);
        check("halt_still",      {31'b0, halted}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("halt_rst_pc",     pc_out, c_RESET_PC);
        check("halt_rst_halted", {31'b0, halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a taken BEQ strobe
        setPc(32'h40);
        @(negedge clk);
        Op = 5'b01011; zeroFlag = 1'b1; imm = 16'h0005; PCWriteCond = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc",    pc_out, c_RESET_PC);
        check("async_taken", {31'b0, branch_taken}, 32'h0);
        PCWriteCond = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef PC_PERF_CNT_EN
        check("cnt_commit_rst", commit_count, 32'h0);
        check("cnt_taken_rst",  taken_count,  32'h0);
        imm = 16'h0002;
        strobe(5'b01011, 1'b1);
        strobe(5'b01011, 1'b0);
        strobe(5'b01011, 1'b1);
        check("cnt_commit", commit_count, 32'h3);
        check("cnt_taken",  taken_count,  32'h2);
        // 0x10 ->+1+2=0x13 ->+1=0x14 ->+1+2=0x17
        check("cnt_pc",     pc_out,       32'h17);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
